// File: rtl/game_outcome_ctrl_if.sv
// Game outcome controller bus.
// The screen/player side (master) drives the game-event inputs. The outcome
// controller (slave) drives the registered status outputs. There is no
// valid/ready handshake: mario_dead and flag_reached are single-frame pulses
// that are sampled on the frame_clk edge that sees them high. Every slave
// output is a registered level, except respawn, which is a registered
// single-frame pulse.
interface game_outcome_ctrl_if;
  logic       game_active;
  logic       mario_dead;
  logic       flag_reached;
  logic       game_over_screen;
  logic       win;
  logic       freeze;
  logic       respawn;
  logic [2:0] lives;
  logic [9:0] time_left;

  modport master (
    output game_active, mario_dead, flag_reached,
    input  game_over_screen, win, freeze, respawn, lives, time_left
  );

  modport slave (
    input  game_active, mario_dead, flag_reached,
    output game_over_screen, win, freeze, respawn, lives, time_left
  );
endinterface

// File: rtl/game_outcome_ctrl.sv
// Game outcome controller: lives, level timer, and the death/flag freeze
// sequencing that leads to a won or lost game.
// Optional feature: define TIME_UP_DEATH_EN so that a level timer resting
// at 0 during play kills the player, exactly as a mario_dead pulse would.
// The FSM state is exposed on o_dbg_state with this encoding:
// 0 IDLE, 1 PLAYING, 2 DYING, 3 FLAG, 4 LOST, 5 WON.
module game_outcome_ctrl #(
  parameter int LIVES_INIT   = 3,
  parameter int TIME_INIT    = 400,
  parameter int TICK_FRAMES  = 24,
  parameter int DEATH_FRAMES = 60,
  parameter int FLAG_FRAMES  = 90
) (
  input  logic                  frame_clk,
  input  logic                  Reset,
  game_outcome_ctrl_if.slave    bus,
  output logic [2:0]            o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PLAYING = 3'd1,
    S_DYING   = 3'd2,
    S_FLAG    = 3'd3,
    S_LOST    = 3'd4,
    S_WON     = 3'd5
  } state_t;

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_lives;
  logic [9:0]  r_time_left;
  logic        r_game_over;
  logic        r_win;
  logic        r_freeze;
  logic        r_respawn;

  logic        w_tick_wrap;
  logic [15:0] w_cnt_tick;
  logic [9:0]  w_time_tick;
  logic        w_time_up;
  logic        w_death;

  // Level-time tick step. The counter is 0 in IDLE, so the frame that
  // enters PLAYING is counted as the first frame of the first tick period.
  always_comb begin
    w_tick_wrap = (r_cnt == 16'(TICK_FRAMES - 1));
    w_cnt_tick  = w_tick_wrap ? 16'd0 : r_cnt + 16'd1;
    w_time_tick = (w_tick_wrap && (r_time_left != 10'd0)) ?
                  r_time_left - 10'd1 : r_time_left;
  end

`ifdef TIME_UP_DEATH_EN
  assign w_time_up = (r_time_left == 10'd0);
`else
  assign w_time_up = 1'b0;
`endif

  // A timer expiry counts as a death, so it also wins over flag_reached.
  assign w_death = bus.mario_dead | w_time_up;

  // Outcome FSM. Reset and a dropped game_active lead to the same IDLE
  // state with every counter reloaded.
  always_ff @(posedge frame_clk) begin
    if (Reset || !bus.game_active) begin
      r_state     <= S_IDLE;
      r_cnt       <= 16'd0;
      r_lives     <= 3'(LIVES_INIT);
      r_time_left <= 10'(TIME_INIT);
      r_game_over <= 1'b0;
      r_win       <= 1'b0;
      r_freeze    <= 1'b0;
      r_respawn   <= 1'b0;
    end else begin
      r_respawn <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_state     <= S_PLAYING;
          r_cnt       <= w_cnt_tick;
          r_time_left <= w_time_tick;
          r_freeze    <= 1'b0;
        end
        S_PLAYING: begin
          if (w_death) begin
            r_state  <= S_DYING;
            r_freeze <= 1'b1;
            r_cnt    <= 16'd0;
          end else if (bus.flag_reached) begin
            r_state  <= S_FLAG;
            r_freeze <= 1'b1;
            r_cnt    <= 16'd0;
          end else begin
            r_cnt       <= w_cnt_tick;
            r_time_left <= w_time_tick;
          end
        end
        S_DYING: begin
          if (r_cnt == 16'(DEATH_FRAMES - 1)) begin
            r_cnt <= 16'd0;
            if (r_lives == 3'd1) begin
              r_lives     <= 3'd0;
              r_state     <= S_LOST;
              r_game_over <= 1'b1;
            end else begin
              r_lives     <= r_lives - 3'd1;
              r_time_left <= 10'(TIME_INIT);
              r_freeze    <= 1'b0;
              r_respawn   <= 1'b1;
              r_state     <= S_PLAYING;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_FLAG: begin
          if (r_cnt == 16'(FLAG_FRAMES - 1)) begin
            r_cnt   <= 16'd0;
            r_state <= S_WON;
            r_win   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_LOST, S_WON: begin
          r_state <= r_state;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.game_over_screen = r_game_over;
  assign bus.win              = r_win;
  assign bus.freeze           = r_freeze;
  assign bus.respawn          = r_respawn;
  assign bus.lives            = r_lives;
  assign bus.time_left        = r_time_left;
  assign o_dbg_state          = r_state;

endmodule
